// File: rtl/if_run_ctrl_pkg.sv
// ============================================================================
//  Module      : if_run_ctrl_pkg
//  Description : Shared constants for the fetch-stage run controller: FSM
//                state encoding, debug command bytes and the end-of-program
//                instruction word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package if_run_ctrl_pkg;

    // Controller states (3-bit encoding is exported on o_state for debug)
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_STEP  = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    // ASCII command bytes from the debug/UART front end
    localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
    localparam logic [7:0] CMD_CONT = 8'h43;  // 'C'
    localparam logic [7:0] CMD_STEP = 8'h53;  // 'S'
    localparam logic [7:0] CMD_EXIT = 8'h45;  // 'E'

    // Instruction that marks the end of a program image
    localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;

    // Width of the enabled-cycle counter
    localparam int CNT_BITS = 32;

endpackage : if_run_ctrl_pkg

`default_nettype wire

// File: rtl/if_run_ctrl_byte_word_packer.sv
// ============================================================================
//  Module      : byte_word_packer
//  Description : Collects MSB-first bytes into instruction words. Holds the
//                previously received bytes and a byte counter; o_word is the
//                word including the byte currently presented, o_word_done
//                flags the byte that completes a word.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_word_packer #(
    parameter int DATA_BITS = 32,
    parameter int BYTE_BITS = 8
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_clr,
    input  logic                 i_shift,
    input  logic [BYTE_BITS-1:0] i_byte,
    output logic [DATA_BITS-1:0] o_word,
    output logic                 o_word_done
);

    localparam int NUM_BYTES = DATA_BITS / BYTE_BITS;
    localparam int CNT_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(NUM_BYTES - 1);

    // Only the bytes preceding the final one need storage; the last byte is
    // taken straight from the input when the word completes.
    logic [DATA_BITS-BYTE_BITS-1:0] r_word;
    logic [CNT_W-1:0]               r_cnt;

    assign o_word      = {r_word, i_byte};
    assign o_word_done = i_shift && (r_cnt == LAST_BYTE);

    // Shift register and byte counter; counter wraps after the last byte
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_clr) begin
            r_word <= '0;
            r_cnt  <= '0;
        end else if (i_shift) begin
            r_word <= o_word[DATA_BITS-BYTE_BITS-1:0];
            r_cnt  <= (r_cnt == LAST_BYTE) ? '0 : r_cnt + 1'b1;
        end
    end

endmodule : byte_word_packer

`default_nettype wire

// File: rtl/if_run_ctrl.sv
// ============================================================================
//  Module      : if_run_ctrl
//  Description : Fetch-stage sequencer. Loads a program byte stream into the
//                instruction memory, then starts the pipeline in continuous
//                or single-step mode until the program ends or is aborted.
//                Optional feature macro IF_RUN_CTRL_CYCLE_CNT_EN adds an
//                enabled-cycle counter on o_cycle_count (tied to 0 otherwise).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_run_ctrl #(
    parameter int                   DATA_BITS = 32,
    parameter int                   BYTE_BITS = 8,
    parameter logic [DATA_BITS-1:0] HALT_WORD = {DATA_BITS{1'b1}}
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic                 i_cmd_valid,
    input  logic [BYTE_BITS-1:0] i_cmd,
    input  logic                 i_data_valid,
    input  logic [BYTE_BITS-1:0] i_data,
    input  logic                 i_full_mem,
    input  logic                 i_empty_mem,
    input  logic                 i_end_program,
    output logic                 o_write_mem,
    output logic [DATA_BITS-1:0] o_instruction,
    output logic                 o_clear_mem,
    output logic                 o_start,
    output logic                 o_enable,
    output logic                 o_flush,
    output logic                 o_busy,
    output logic                 o_error,
    output logic [2:0]           o_state,
    output logic [31:0]          o_cycle_count
);

    import if_run_ctrl_pkg::*;

    state_t               r_state;
    logic                 r_write;
    logic [DATA_BITS-1:0] r_instr;
    logic                 r_clear;
    logic                 r_start;
    logic                 r_enable;
    logic                 r_flush;
    logic                 r_error;

    logic                 w_exit;
    logic                 w_step_cmd;
    logic                 w_abort;
    logic                 w_pk_clr;
    logic                 w_pk_shift;
    logic [DATA_BITS-1:0] w_word;
    logic                 w_word_done;

    assign w_exit     = i_cmd_valid && (i_cmd == CMD_EXIT);
    assign w_step_cmd = i_cmd_valid && (i_cmd == CMD_STEP);
    assign w_abort    = (r_state == ST_LOAD) && w_exit;

    // Packer is held empty outside LOAD so every load starts word-aligned;
    // an abort also discards any partially assembled word.
    assign w_pk_clr   = (r_state != ST_LOAD) || w_abort;
    assign w_pk_shift = i_data_valid && (r_state == ST_LOAD) && !w_abort;

    byte_word_packer #(
        .DATA_BITS (DATA_BITS),
        .BYTE_BITS (BYTE_BITS)
    ) u_packer (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clr       (w_pk_clr),
        .i_shift     (w_pk_shift),
        .i_byte      (i_data),
        .o_word      (w_word),
        .o_word_done (w_word_done)
    );

    // Sequencer FSM; every output is a flop, pulses default low each cycle
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= ST_IDLE;
            r_write  <= 1'b0;
            r_instr  <= '0;
            r_clear  <= 1'b0;
            r_start  <= 1'b0;
            r_enable <= 1'b0;
            r_flush  <= 1'b0;
            r_error  <= 1'b0;
        end else begin
            r_write <= 1'b0;
            r_clear <= 1'b0;
            r_start <= 1'b0;
            r_flush <= 1'b0;
            r_error <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_enable <= 1'b0;
                    if (i_cmd_valid) begin
                        case (i_cmd)
                            CMD_LOAD: begin
                                r_clear <= 1'b1;
                                r_state <= ST_CLEAR;
                            end
                            CMD_CONT: begin
                                if (i_empty_mem) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_start  <= 1'b1;
                                    r_enable <= 1'b1;
                                    r_state  <= ST_RUN;
                                end
                            end
                            CMD_STEP: begin
                                if (i_empty_mem) begin
                                    r_error <= 1'b1;
                                end else begin
                                    r_start <= 1'b1;
                                    r_state <= ST_STEP;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                ST_CLEAR: begin
                    r_state <= ST_LOAD;
                end
                ST_LOAD: begin
                    if (w_abort) begin
                        r_state <= ST_IDLE;
                    end else if (w_word_done) begin
                        // The halt word is always written so the pipeline
                        // can detect the end; only program words honour full
                        if (w_word == HALT_WORD) begin
                            r_write <= 1'b1;
                            r_instr <= w_word;
                            r_state <= ST_IDLE;
                        end else if (i_full_mem) begin
                            r_error <= 1'b1;
                            r_state <= ST_IDLE;
                        end else begin
                            r_write <= 1'b1;
                            r_instr <= w_word;
                        end
                    end
                end
                ST_RUN: begin
                    if (i_end_program || w_exit) begin
                        r_enable <= 1'b0;
                        r_flush  <= 1'b1;
                        r_state  <= ST_DONE;
                    end else begin
                        r_enable <= 1'b1;
                    end
                end
                ST_STEP: begin
                    // End of program takes priority over a step request
                    r_enable <= 1'b0;
                    if (i_end_program || w_exit) begin
                        r_flush <= 1'b1;
                        r_state <= ST_DONE;
                    end else if (w_step_cmd) begin
                        r_enable <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_enable <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    r_enable <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IF_RUN_CTRL_CYCLE_CNT_EN
    logic [CNT_BITS-1:0] r_cycle_count;

    // Counts enabled cycles; the start pulse coincides with the first RUN
    // cycle, so that cycle is counted while clearing
    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_cycle_count <= '0;
        end else if (r_start) begin
            r_cycle_count <= {{(CNT_BITS-1){1'b0}}, r_enable};
        end else if (r_enable && (r_cycle_count != {CNT_BITS{1'b1}})) begin
            r_cycle_count <= r_cycle_count + 1'b1;
        end
    end

    assign o_cycle_count = r_cycle_count;
`else
    assign o_cycle_count = '0;
`endif

    assign o_write_mem   = r_write;
    assign o_instruction = r_instr;
    assign o_clear_mem   = r_clear;
    assign o_start       = r_start;
    assign o_enable      = r_enable;
    assign o_flush       = r_flush;
    assign o_error       = r_error;
    assign o_state       = r_state;
    assign o_busy        = (r_state != ST_IDLE);

endmodule : if_run_ctrl

`default_nettype wire

// File: tb/tb_if_run_ctrl.sv
// ============================================================================
//  Module      : tb_if_run_ctrl
//  Description : Self-checking bench for if_run_ctrl. A monitor tallies
//                output pulses and collected memory writes; each scenario
//                task compares them with expectations derived from the
//                command/byte stream it generated.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_if_run_ctrl;

    localparam logic [7:0]  L_CMD = 8'h4C;
    localparam logic [7:0]  C_CMD = 8'h43;
    localparam logic [7:0]  S_CMD = 8'h53;
    localparam logic [7:0]  E_CMD = 8'h45;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
    localparam logic [2:0]  S_IDLE = 3'd0;
    localparam logic [2:0]  S_RUN  = 3'd3;
    localparam logic [2:0]  S_STEP = 3'd4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic        data_valid = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        full_mem = 1'b0;
    logic        empty_mem = 1'b0;
    logic        end_prog = 1'b0;

    logic        o_write_mem;
    logic [31:0] o_instruction;
    logic        o_clear_mem;
    logic        o_start;
    logic        o_enable;
    logic        o_flush;
    logic        o_busy;
    logic        o_error;
    logic [2:0]  o_state;
    logic [31:0] o_cycle_count;

    int n_checks = 0;
    int n_fail   = 0;

    // Monitor tallies
    int          m_clear, m_start, m_flush, m_error, m_enable, m_dbl;
    logic [31:0] got_w[$];
    logic [4:0]  prev_p = '0;

    // Stimulus for load scenarios
    logic [31:0] ld_words[$];

    always #5 clk = ~clk;

    if_run_ctrl dut (
        .i_clk         (clk),
        .i_reset       (rst_n),
        .i_cmd_valid   (cmd_valid),
        .i_cmd         (cmd),
        .i_data_valid  (data_valid),
        .i_data        (data),
        .i_full_mem    (full_mem),
        .i_empty_mem   (empty_mem),
        .i_end_program (end_prog),
        .o_write_mem   (o_write_mem),
        .o_instruction (o_instruction),
        .o_clear_mem   (o_clear_mem),
        .o_start       (o_start),
        .o_enable      (o_enable),
        .o_flush       (o_flush),
        .o_busy        (o_busy),
        .o_error       (o_error),
        .o_state       (o_state),
        .o_cycle_count (o_cycle_count)
    );

    // Sample outputs mid-cycle
    always @(negedge clk) begin
        logic [4:0] cur;
        cur = {o_clear_mem, o_start, o_flush, o_error, o_write_mem};
        if (o_write_mem) got_w.push_back(o_instruction);
        if (o_clear_mem) m_clear++;
        if (o_start)     m_start++;
        if (o_flush)     m_flush++;
        if (o_error)     m_error++;
        if (o_enable)    m_enable++;
        if ((cur & prev_p) != 5'd0) m_dbl++;
        prev_p = cur;
    end

    task automatic clr_mon();
        m_clear = 0; m_start = 0; m_flush = 0; m_error = 0; m_enable = 0; m_dbl = 0;
        got_w.delete();
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_cmd(input logic [7:0] c);
        cmd = c; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0; cmd = 8'($urandom);
    endtask

    task automatic send_byte(input logic [7:0] b);
        data = b; data_valid = 1'b1;
        tick();
        data_valid = 1'b0; data = 8'($urandom);
        idle($urandom_range(0, 2));
    endtask

    function automatic int exp_cc(input int n);
`ifdef IF_RUN_CTRL_CYCLE_CNT_EN
        return n;
`else
        return 0 * n;
`endif
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        idle(5);
        n_checks++;
        if ({o_write_mem, o_instruction, o_clear_mem, o_start, o_enable, o_flush,
             o_busy, o_error, o_state, o_cycle_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_hold: outputs not all zero (state=%0d instr=%h busy=%b)",
                     o_state, o_instruction, o_busy);
        end
        #3 rst_n = 1'b1;
        tick();
        n_checks++;
        if (o_state !== S_IDLE || o_busy !== 1'b0 || o_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: state=%0d busy=%b enable=%b, required 0/0/0",
                     o_state, o_busy, o_enable);
        end
    endtask

    // Loads ld_words; full asserted on word index full_at (-1: never)
    task automatic do_load(input string name, input int full_at);
        logic [31:0] exp_w[$];
        int          exp_err;
        exp_err = 0;
        foreach (ld_words[i]) begin
            if (ld_words[i] == HALT) begin
                exp_w.push_back(ld_words[i]);
                break;
            end else if (i == full_at) begin
                exp_err = 1;
                break;
            end
            exp_w.push_back(ld_words[i]);
        end
        clr_mon();
        send_cmd(L_CMD);
        idle(1);
        foreach (ld_words[i]) begin
            full_mem = (i == full_at) || (ld_words[i] == HALT && $urandom_range(0, 1) == 1);
            for (int b = 0; b < 4; b++) send_byte(ld_words[i][31-8*b -: 8]);
        end
        full_mem = 1'b0;
        idle(3);
        n_checks++;
        if (got_w.size() != exp_w.size()) begin
            n_fail++;
            $display("FAIL %s_write_count: got %0d writes, required %0d", name, got_w.size(), exp_w.size());
        end else begin
            foreach (exp_w[i]) begin
                n_checks++;
                if (got_w[i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL %s_word%0d: got %h, required %h", name, i, got_w[i], exp_w[i]);
                end
            end
        end
        n_checks++;
        if (m_error != exp_err || m_clear != 1 || o_state !== S_IDLE || m_dbl != 0) begin
            n_fail++;
            $display("FAIL %s_flags: error=%0d clear=%0d state=%0d dbl=%0d, required %0d/1/0/0",
                     name, m_error, m_clear, o_state, m_dbl, exp_err);
        end
    endtask

    task automatic test_load_basic();
        ld_words = '{32'h12345678, HALT};
        do_load("load_basic", -1);
    endtask

    task automatic test_load_full();
        ld_words = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, HALT};
        do_load("load_full", 1);
    endtask

    task automatic test_load_random();
        for (int r = 0; r < 4; r++) begin
            int n, fa;
            ld_words.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) ld_words.push_back($urandom & 32'hFFFF_FFFE);
            ld_words.push_back(HALT);
            fa = ($urandom_range(0, 1) == 1) ? $urandom_range(0, n - 1) : -1;
            do_load("load_rand", fa);
        end
    endtask

    task automatic test_empty_run();
        clr_mon();
        empty_mem = 1'b1;
        send_cmd(C_CMD);
        idle(1);
        send_cmd(S_CMD);
        for (int i = 0; i < 4; i++) send_byte(8'($urandom));
        idle(2);
        empty_mem = 1'b0;
        n_checks++;
        if (m_error != 2 || m_start != 0 || m_enable != 0 || o_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL empty_run: error=%0d start=%0d enable=%0d state=%0d, required 2/0/0/0",
                     m_error, m_start, m_enable, o_state);
        end
        n_checks++;
        if (got_w.size() != 0) begin
            n_fail++;
            $display("FAIL idle_data_ignored: got %0d writes, required 0", got_w.size());
        end
    endtask

    task automatic test_run(input int k, input bit use_exit);
        clr_mon();
        send_cmd(C_CMD);
        n_checks++;
        if (o_state !== S_RUN || o_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL run_enter: state=%0d busy=%b, required 3/1", o_state, o_busy);
        end
        idle(k - 1);
        if (use_exit) begin
            cmd = E_CMD; cmd_valid = 1'b1;
        end else begin
            end_prog = 1'b1;
        end
        tick();
        cmd_valid = 1'b0; end_prog = 1'b0;
        idle(3);
        n_checks++;
        if (m_start != 1 || m_enable != k || m_flush != 1 || o_state !== S_IDLE || m_dbl != 0) begin
            n_fail++;
            $display("FAIL run_k%0d: start=%0d enable=%0d flush=%0d state=%0d, required 1/%0d/1/0",
                     k, m_start, m_enable, m_flush, o_state, k);
        end
        n_checks++;
        if (o_cycle_count !== 32'(exp_cc(k))) begin
            n_fail++;
            $display("FAIL run_cycle_count: got %0d, required %0d", o_cycle_count, exp_cc(k));
        end
    endtask

    task automatic test_step(input int m, input bit end_with_s);
        clr_mon();
        send_cmd(S_CMD);
        n_checks++;
        if (o_state !== S_STEP || o_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL step_enter: state=%0d enable=%b, required 4/0", o_state, o_enable);
        end
        for (int j = 0; j < m; j++) begin
            idle($urandom_range(0, 2));
            send_cmd(S_CMD);
        end
        idle(1);
        end_prog = 1'b1;
        if (end_with_s) begin
            cmd = S_CMD; cmd_valid = 1'b1;
        end
        tick();
        end_prog = 1'b0; cmd_valid = 1'b0;
        idle(3);
        n_checks++;
        if (m_enable != m || m_start != 1 || m_flush != 1 || o_state !== S_IDLE) begin
            n_fail++;
            $display("FAIL step_m%0d: enable=%0d start=%0d flush=%0d state=%0d, required %0d/1/1/0",
                     m, m_enable, m_start, m_flush, o_state, m);
        end
        n_checks++;
        if (o_cycle_count !== 32'(exp_cc(m))) begin
            n_fail++;
            $display("FAIL step_cycle_count: got %0d, required %0d", o_cycle_count, exp_cc(m));
        end
    endtask

    task automatic test_abort();
        logic [31:0] w0;
        w0 = $urandom & 32'hFFFF_FFFE;
        clr_mon();
        send_cmd(L_CMD);
        idle(1);
        for (int b = 0; b < 4; b++) send_byte(w0[31-8*b -: 8]);
        send_byte(8'h5A);
        send_byte(8'hA5);
        send_cmd(E_CMD);
        idle(2);
        n_checks++;
        if (got_w.size() != 1 || o_state !== S_IDLE || m_error != 0) begin
            n_fail++;
            $display("FAIL abort_flags: writes=%0d state=%0d error=%0d, required 1/0/0",
                     got_w.size(), o_state, m_error);
        end else begin
            n_checks++;
            if (got_w[0] !== w0) begin
                n_fail++;
                $display("FAIL abort_word: got %h, required %h", got_w[0], w0);
            end
        end
        // A following load must start word-aligned
        ld_words = '{32'h0BADF00D, HALT};
        do_load("after_abort", -1);
    endtask

    task automatic test_async_reset();
        send_cmd(C_CMD);
        idle(2);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (o_enable !== 1'b0 || o_state !== S_IDLE || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: enable=%b state=%0d busy=%b, required 0/0/0",
                     o_enable, o_state, o_busy);
        end
        #3 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        test_reset();
        test_load_basic();
        test_empty_run();
        test_run(7, 1'b0);
        test_run($urandom_range(1, 12), 1'b1);
        test_step(3, 1'b0);
        test_step(0, 1'b1);
        test_step($urandom_range(1, 5), 1'b1);
        test_load_full();
        test_load_random();
        test_abort();
        test_async_reset();
        test_run(1, 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_run_ctrl

`default_nettype wire
